// File: rtl/mux_crc_engine.sv
// mux_crc_engine: serial MSB-first CRC/LFSR engine, one message bit per cycle.
// Every 2-input XOR in the datapath is a mux_crc_xor_cell (4:1 mux with a
// constant truth table), so the whole block maps onto the mux-cell fabric.
// Optional feature macro: CRC_XOROUT_EN (crc_out = crc ^ XOROUT, built from
// mux XOR cells). Without it, crc_out is the CRC register and XOROUT is ignored.

// 2-input XOR as a 4:1 mux: the inputs select one entry of the XOR truth table.
module mux_crc_xor_cell (
   input  logic a,
   input  logic b,
   output logic y
);
   logic [3:0] truth_table;

   assign truth_table = 4'b0110;
   assign y = truth_table[{a, b}];
endmodule

module mux_crc_engine #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] POLY      = 8'h07,
   parameter logic [WIDTH-1:0] INIT      = 8'h00,
   parameter int               DATA_BITS = 8,
   parameter logic [WIDTH-1:0] XOROUT    = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     crc_out
);

   // Bit counter wide enough for DATA_BITS-1; at least one bit for DATA_BITS=1.
   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Reject illegal configurations at elaboration time.
   generate
      if (WIDTH < 2 || WIDTH > 32 || DATA_BITS < 1 || DATA_BITS > 32) begin : g_bad_params
         $error("mux_crc_engine: WIDTH must be 2..32 and DATA_BITS 1..32");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     crc_reg, crc_next;
   logic [DATA_BITS-1:0] shreg_reg, shreg_next;
   logic [CW-1:0]        cnt_reg, cnt_next;

   logic                 fb;
   logic [WIDTH-1:0]     crc_shifted;
   logic [WIDTH-1:0]     crc_stepped;

   // Feedback bit: CRC MSB combined with the next message bit (MSB first).
   mux_crc_xor_cell u_fb_xor (
      .a (crc_reg[WIDTH-1]),
      .b (shreg_reg[DATA_BITS-1]),
      .y (fb)
   );

   assign crc_shifted = {crc_reg[WIDTH-2:0], 1'b0};

   // Polynomial taps: an XOR cell only where POLY has a 1, plain wire elsewhere.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
         if (POLY[gi]) begin : g_xor
            mux_crc_xor_cell u_tap_xor (
               .a (crc_shifted[gi]),
               .b (fb),
               .y (crc_stepped[gi])
            );
         end else begin : g_wire
            assign crc_stepped[gi] = crc_shifted[gi];
         end
      end
   endgenerate

   // State and datapath registers; async reset returns to IDLE with the seed loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         crc_reg   <= INIT;
         shreg_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         crc_reg   <= crc_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state, datapath update and handshake/status outputs.
   always_comb begin
      state_next = state_reg;
      crc_next   = crc_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            // Ready is withheld while reset is asserted.
            in_ready = !rst;
            if (in_valid) begin
               shreg_next = data_in;
               crc_next   = start ? INIT : crc_reg;
               cnt_next   = CW'(DATA_BITS - 1);
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy       = 1'b1;
            crc_next   = crc_stepped;
            shreg_next = shreg_reg << 1;
            if (cnt_reg == '0) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef CRC_XOROUT_EN
   // Final XOR mask applied on the output only; the running CRC stays unmasked.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xorout
         mux_crc_xor_cell u_out_xor (
            .a (crc_reg[gi]),
            .b (XOROUT[gi]),
            .y (crc_out[gi])
         );
      end
   endgenerate
`else
   assign crc_out = crc_reg;
`endif

endmodule

// File: tb/tb_mux_crc_engine.sv
// Self-checking bench for mux_crc_engine (default WIDTH=8, POLY=0x07, INIT=0,
// DATA_BITS=8). The driver pushes expected CRCs into a scoreboard queue at
// acceptance; a negedge monitor pops and compares on each done pulse.
module tb_mux_crc_engine;

   localparam int         W  = 8;
   localparam int         D  = 8;
   localparam logic [7:0] P  = 8'h07;
   localparam logic [7:0] IN = 8'h00;
`ifdef CRC_XOROUT_EN
   localparam logic [7:0] XO = 8'hFF;
`else
   localparam logic [7:0] XO = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [7:0] crc_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_count = 0;

   logic [7:0] exp_q[$];
   int         acc_q[$];
   logic [7:0] model_crc = IN;
   logic [7:0] last_out;
   bit         have_last = 1'b0;

   mux_crc_engine #(
      .WIDTH     (W),
      .POLY      (P),
      .INIT      (IN),
      .DATA_BITS (D),
      .XOROUT    (XO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_in  (data_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .crc_out  (crc_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Byte-at-a-time CRC: fold the whole byte into the register, then divide.
   function automatic logic [7:0] model(input logic [7:0] prev, input logic [7:0] d, input bit s);
      logic [7:0] c;
      c = s ? IN : prev;
      c = c ^ d;
      for (int k = 0; k < 8; k++) begin
         if (c[7]) c = (c << 1) ^ P;
         else      c = c << 1;
      end
      return c;
   endfunction

   // Monitor: score each done pulse, and check crc_out holds while idle.
   always @(negedge clk) begin
      logic [7:0] e;
      int a;
      if (rst) begin
         last_out  = IN ^ XO;
         have_last = 1'b1;
      end else if (done) begin
         done_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got crc %02h, expected no done", crc_out);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("crc", 32'(crc_out), 32'(e));
            check("latency", 32'(cyc - a), 32'(D));
            last_out = e;
            $display("done #%0d: crc_out=%02h expected=%02h cycles=%0d", done_count, crc_out, e, cyc - a);
         end
      end else if (in_ready && !busy && have_last) begin
         check("idle_hold", 32'(crc_out), 32'(last_out));
      end
   end

   task automatic send(input logic [7:0] d, input bit s, input bit expect_done, input logic [7:0] e);
      int n;
      n = 0;
      @(negedge clk);
      data_in  = d;
      start    = s;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
         in_valid = 1'b0;
         return;
      end
      if (expect_done) begin
         exp_q.push_back(e);
         acc_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m;
      logic [7:0] d;
      bit         s;
      int         dc;
      int         bcnt;
      int         rcnt;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_crc_out", 32'(crc_out), 32'(IN ^ XO));
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Directed single words
      send(8'h01, 1'b1, 1'b1, 8'h07 ^ XO);
      send(8'h80, 1'b1, 1'b1, 8'h89 ^ XO);
      send(8'h00, 1'b1, 1'b1, 8'h00 ^ XO);
      drain();
      model_crc = 8'h00;

      // "123456789" check value
      dc = done_count;
      for (int i = 0; i < 9; i++) begin
         d = 8'h31 + 8'(i);
         m = model(model_crc, d, i == 0);
         send(d, i == 0, 1'b1, ((i == 8) ? 8'hF4 : m) ^ XO);
         model_crc = m;
      end
      drain();
      check("ascii_done_pulses", 32'(done_count - dc), 32'd9);

      // in_valid held high with changing data while shifting
      @(negedge clk);
      data_in  = 8'h55;
      start    = 1'b0;
      in_valid = 1'b1;
      m = model(model_crc, 8'h55, 1'b0);
      exp_q.push_back(m ^ XO);
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      model_crc = m;
      bcnt = 0;
      rcnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (in_ready) rcnt++;
         data_in = 8'($urandom);
      end
      check("busy_cycles", 32'(bcnt), 32'd8);
      check("ready_while_busy", 32'(rcnt), 32'd0);
      @(negedge clk);
      check("ready_back_in_idle", 32'(in_ready), 32'd1);
      data_in = 8'h3C;
      m = model(model_crc, 8'h3C, 1'b0);
      exp_q.push_back(m ^ XO);
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      model_crc = m;
      drain();

      // Reset in the 4th shift cycle aborts the word
      dc = done_count;
      send(8'h80, 1'b1, 1'b0, 8'h00);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_crc_out", 32'(crc_out), 32'(IN ^ XO));
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_crc = IN;
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(done_count - dc), 32'd0);
      send(8'h01, 1'b1, 1'b1, 8'h07 ^ XO);
      model_crc = 8'h07;
      drain();

      // Randomised frames
      for (int i = 0; i < 40; i++) begin
         s = (i == 0) || ($urandom_range(0, 3) == 0);
         d = 8'($urandom);
         m = model(model_crc, d, s);
         send(d, s, 1'b1, m ^ XO);
         model_crc = m;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
